// File: rtl/xg_pon_rx_frame_buffer.sv
// Store-and-forward frame buffer behind the XG-PON frame synchroniser: frames are committed on TLAST,
// dropped on overflow or TVALID gap, and replayed on a backpressured AXI-Stream master.
module xg_pon_rx_frame_buffer #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [31:0]       axis_TDATA_in,
  input  logic              axis_TVALID_in,
  input  logic [3:0]        axis_TKEEP_in,
  input  logic              axis_TLAST_in,
  input  logic              axis_TUSER_in,
  output logic              axis_TREADY_out,
  output logic [31:0]       axis_TDATA_out,
  output logic              axis_TVALID_out,
  output logic [3:0]        axis_TKEEP_out,
  output logic              axis_TLAST_out,
  output logic              axis_TUSER_out,
  input  logic              axis_TREADY_in,
  output logic [CNT_W-1:0]  frames_committed,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [ADDR_W:0]   buffer_level
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = 38;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     wr_ptr, commit_ptr, rd_ptr, used;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   in_word_p0, word_p1, word_p2;
  logic                ready_q, in_vld_p0, full, wr_en, commit, drop;
  logic                readable, rd_en, out_load, vld_p1, vld_p2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign in_vld_p0  = axis_TVALID_in & ready_q;
  assign in_word_p0 = {axis_TUSER_in, axis_TLAST_in, axis_TKEEP_in, axis_TDATA_in};
  // Full is judged against rd_ptr before this cycle's read, so a freed slot is usable next cycle.
  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == DEPTH_P);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (in_vld_p0) begin
          if (full) begin
            if (axis_TLAST_in) begin
              drop      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else begin
            wr_en = 1'b1;
            if (axis_TLAST_in) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = FILL;
            end
          end
        end else if (state == FILL) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (!in_vld_p0 || axis_TLAST_in) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= IDLE;
      ready_q          <= 1'b0;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      frames_committed <= '0;
      frames_dropped   <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (drop)   wr_ptr <= commit_ptr;
      if (commit) begin
        commit_ptr       <= wr_ptr + 1'b1;
        frames_committed <= sat_inc(frames_committed);
      end
      if (drop)   frames_dropped <= sat_inc(frames_dropped);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= in_word_p0;
  end

  // Stage p1: registered RAM read; stage p2: output register. p1 holds its word while p2 is stalled.
  assign readable = (rd_ptr != commit_ptr);
  assign out_load = vld_p1 && (!vld_p2 || axis_TREADY_in);
  assign rd_en    = readable && (!vld_p1 || out_load);

  always_ff @(posedge clk_in) begin
    if (rd_en) word_p1 <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      vld_p1 <= rd_en | (vld_p1 & ~out_load);
      vld_p2 <= out_load | (vld_p2 & ~axis_TREADY_in);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)   word_p2 <= '0;
    else if (out_load) word_p2 <= word_p1;
  end

  assign axis_TREADY_out = ready_q;
  assign axis_TVALID_out = vld_p2;
  assign axis_TUSER_out  = word_p2[37];
  assign axis_TLAST_out  = word_p2[36];
  assign axis_TKEEP_out  = word_p2[35:32];
  assign axis_TDATA_out  = word_p2[31:0];
  assign buffer_level    = commit_ptr - rd_ptr;
endmodule
